// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared state encoding and FIFO timing constants
//
// Purpose: definitions shared by the sample-FIFO reader slice.
//   state_t           : reader state (IDLE, PRIME, STREAM)
//   FIFO_READ_LATENCY : cycles from accepted dequeue to fifo_data_valid

package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int FIFO_READ_LATENCY = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - valid/ready sample stream interface
//
// Purpose: first-word-fall-through stream from the reader to a consumer.
// Signals:
//   m_data  [WIDTH] : stream word (head of the reader's skid buffer)
//   m_valid         : m_data holds a word
//   m_ready         : consumer accepts the word this cycle
// Modports: master (reader side), slave (consumer side).

interface fifo_stream_reader_if #(
  parameter int WIDTH = 12
);

  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/fifo_stream_reader_sample_skid_buf.sv
// rtl/fifo_stream_reader_sample_skid_buf.sv - circular skid buffer for returned FIFO words
//
// Purpose: WIDTH x DEPTH register array with wrapping read/write pointers.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   push, push_data [WIDTH] : write a word (ignored while full)
//   pop                     : retire the head word (ignored while empty)
//   head [WIDTH]            : registered word at the read pointer
//   occupancy               : number of stored words, 0..DEPTH

module sample_skid_buf #(
  parameter int  WIDTH = 12,
  parameter int  DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so that non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push while full is a protocol violation upstream; the word is dropped.
  assign do_push = push && (occupancy != OCC_W'(DEPTH));
  assign do_pop  = pop && (occupancy != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: ;
      endcase
    end
  end

  // Head comes straight from storage, so it only moves on a pop.
  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - reader controller turning the sample FIFO into a FWFT stream
//
// Purpose: issues credit-limited dequeues to a fixed-latency FIFO, captures the
// returned words in a skid buffer, and streams them after an initial prime.
// Optional feature macro: FIFO_READER_UNDERRUN_COUNT_EN adds underrun_count.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   enable                  : run request; low stops new dequeues
//   fifo_empty              : FIFO empty flag
//   fifo_dequeue            : dequeue request to the FIFO (combinational)
//   fifo_data [WIDTH]       : FIFO read data
//   fifo_data_valid         : FIFO read data valid, READ_LATENCY after dequeue
//   stream (master)         : m_data / m_valid / m_ready output stream
//   underrun                : one-cycle pulse after a starved STREAM cycle
//   underrun_count [16]     : saturating underrun pulse count (macro only)

module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH        = 12,
  parameter int READ_LATENCY = FIFO_READ_LATENCY,
  parameter int SKID_DEPTH   = 4,
  parameter int PRIME_LEVEL  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_dequeue,
  input  logic [WIDTH-1:0]     fifo_data,
  input  logic                 fifo_data_valid,
  fifo_stream_reader_if.master stream,
  output logic                 underrun
`ifdef FIFO_READER_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]          underrun_count
`endif
);

  localparam int OCC_W  = $clog2(SKID_DEPTH + 1);
  localparam int INF_W  = $clog2(READ_LATENCY + 1);
  localparam int CRED_W = OCC_W + 1;

  state_t            state;
  state_t            state_next;
  logic [INF_W-1:0]  inflight;
  logic [OCC_W-1:0]  occupancy;
  logic [CRED_W-1:0] credit;
  logic              pop;
  logic              starve;

  // Credit counts every skid slot already promised: words stored plus words
  // still coming back. Registered values only, so a pop frees its slot one
  // cycle later and the skid can never overflow.
  assign credit = CRED_W'(inflight) + CRED_W'(occupancy);

  assign fifo_dequeue = (state != IDLE) && enable && !fifo_empty &&
                        (credit < CRED_W'(SKID_DEPTH));

  assign stream.m_valid = (state == STREAM) && (occupancy != '0);
  assign pop            = stream.m_valid && stream.m_ready;
  assign starve         = (state == STREAM) && stream.m_ready && (occupancy == '0);

  sample_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_data_valid),
    .push_data (fifo_data),
    .pop       (pop),
    .head      (stream.m_data),
    .occupancy (occupancy)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Returns keep being captured in IDLE; only new dequeues stop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = PRIME;
      end
      PRIME: begin
        if (!enable) state_next = IDLE;
        else if (occupancy >= OCC_W'(PRIME_LEVEL)) state_next = STREAM;
      end
      STREAM: begin
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Decrement saturates at zero so a dropped or stray return cannot wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
    end else begin
      case ({fifo_dequeue, fifo_data_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= starve;
    end
  end

`ifdef FIFO_READER_UNDERRUN_COUNT_EN
  // A fresh run (IDLE -> PRIME) starts the count from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underrun_count <= '0;
    end else if ((state == IDLE) && enable) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - randomized self-checking bench for fifo_stream_reader

module tb_fifo_stream_reader;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int PLVL  = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             fifo_dequeue;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_data_valid = 1'b0;
  logic             underrun;
`ifdef FIFO_READER_UNDERRUN_COUNT_EN
  logic [15:0]      underrun_count;
`endif

  fifo_stream_reader_if #(.WIDTH(WIDTH)) stream ();

  always #5 clock = ~clock;

  fifo_stream_reader #(
    .WIDTH        (WIDTH),
    .READ_LATENCY (2),
    .SKID_DEPTH   (DEPTH),
    .PRIME_LEVEL  (PLVL)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .fifo_empty      (fifo_empty),
    .fifo_dequeue    (fifo_dequeue),
    .fifo_data       (fifo_data),
    .fifo_data_valid (fifo_data_valid),
    .stream          (stream),
    .underrun        (underrun)
`ifdef FIFO_READER_UNDERRUN_COUNT_EN
    ,
    .underrun_count  (underrun_count)
`endif
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Reference model: FIFO contents, words in flight (2-stage return pipe),
  // words held by the reader, run phase, pending underrun pulse.
  logic [WIDTH-1:0] src_q[$];
  logic [WIDTH-1:0] skid_q[$];
  bit               v1, v2;
  logic [WIDTH-1:0] d1, d2;
  int               st = 0;     // 0 idle, 1 priming, 2 streaming
  bit               under_pend = 1'b0;
  int               ucnt = 0;
  int               feed_pct = 0;

  // Observed activity counters, cleared by tests around windows of interest.
  int obs_deq, obs_valid, obs_pop;

  task automatic model_clear();
    src_q.delete();
    skid_q.delete();
    v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0;
    st = 0; under_pend = 1'b0; ucnt = 0;
  endtask

  task automatic step(input bit en, input bit rdy);
    bit               exp_deq, exp_valid, cap;
    logic [WIDTH-1:0] w;
    int               occ;
    @(negedge clock);
    if (feed_pct > 0 && $urandom_range(99) < feed_pct) src_q.push_back(WIDTH'($urandom));
    enable          = en;
    stream.m_ready  = rdy;
    fifo_empty      = (src_q.size() == 0);
    fifo_data_valid = v2;
    fifo_data       = d2;
    #1;
    occ       = skid_q.size();
    exp_deq   = (st != 0) && en && !fifo_empty && (int'(v1) + int'(v2) + occ) < DEPTH;
    exp_valid = (st == 2) && (occ != 0);
    vectors += 3;
    if (fifo_dequeue !== exp_deq) begin
      errors++;
      $display("FAIL dequeue cyc=%0d got=%b exp=%b", cyc, fifo_dequeue, exp_deq);
    end
    if (stream.m_valid !== exp_valid) begin
      errors++;
      $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, stream.m_valid, exp_valid);
    end
    if (underrun !== under_pend) begin
      errors++;
      $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, underrun, under_pend);
    end
    if (exp_valid) begin
      vectors++;
      if (stream.m_data !== skid_q[0]) begin
        errors++;
        $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, stream.m_data, skid_q[0]);
      end
    end
`ifdef FIFO_READER_UNDERRUN_COUNT_EN
    vectors++;
    if (underrun_count !== 16'(ucnt)) begin
      errors++;
      $display("FAIL underrun_count cyc=%0d got=%0d exp=%0d", cyc, underrun_count, ucnt);
    end
`endif
    obs_deq   += int'(fifo_dequeue === 1'b1);
    obs_valid += int'(stream.m_valid === 1'b1);
    obs_pop   += int'(stream.m_valid === 1'b1 && rdy);
    // advance the model across the coming edge
    w = '0;
    if (exp_deq) w = src_q.pop_front();
    cap = v2 && (occ < DEPTH);
    if (st == 0 && en) ucnt = 0;
    else if (under_pend && ucnt < 65535) ucnt++;
    under_pend = (st == 2) && rdy && (occ == 0);
    case (st)
      0: if (en) st = 1;
      1: if (!en) st = 0; else if (occ >= PLVL) st = 2;
      default: if (!en) st = 0;
    endcase
    if (exp_valid && rdy) skid_q.delete(0);
    if (cap) skid_q.push_back(d2);
    v2 = v1; d2 = d1; v1 = exp_deq; d1 = w;
    cyc++;
    @(posedge clock);
  endtask

  task automatic clear_obs();
    obs_deq = 0; obs_valid = 0; obs_pop = 0;
  endtask

  task automatic keep_fed();
    while (src_q.size() < 4) src_q.push_back(WIDTH'($urandom));
  endtask

  task automatic test_reset();
    enable = 1'b1; fifo_empty = 1'b0; stream.m_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors += 4;
    if (fifo_dequeue !== 1'b0) begin errors++; $display("FAIL reset_dequeue got=%b exp=0", fifo_dequeue); end
    if (stream.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", stream.m_valid); end
    if (stream.m_data !== '0) begin errors++; $display("FAIL reset_m_data got=%h exp=0", stream.m_data); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    enable = 1'b0; fifo_empty = 1'b1; stream.m_ready = 1'b0;
    model_clear();
    reset_n = 1'b1;
  endtask

  task automatic test_priming();
    int first_valid = -1;
    int deq_early = 0;
    int pops_early = 0;
    feed_pct = 0;
    for (int i = 0; i < 10; i++) src_q.push_back(WIDTH'(i));
    clear_obs();
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1);
      if (first_valid < 0 && obs_valid > 0) first_valid = i;
      if (i == 7) deq_early = obs_deq;
      if (i == 17) pops_early = obs_pop;
    end
    vectors += 3;
    if (first_valid != 8) begin errors++; $display("FAIL prime_first_valid got=%0d exp=8", first_valid); end
    if (deq_early != 4) begin errors++; $display("FAIL prime_dequeues got=%0d exp=4", deq_early); end
    if (pops_early != 10) begin errors++; $display("FAIL prime_no_gap_pops got=%0d exp=10", pops_early); end
  endtask

  task automatic test_throughput();
    for (int i = 0; i < 30; i++) begin
      if (i == 14) clear_obs();
      keep_fed();
      step(1'b1, 1'b1);
    end
    vectors += 2;
    if (obs_pop != 16) begin errors++; $display("FAIL throughput_pops got=%0d exp=16", obs_pop); end
    if (obs_deq != 16) begin errors++; $display("FAIL throughput_dequeues got=%0d exp=16", obs_deq); end
  endtask

  task automatic test_backpressure();
    int valid_stall;
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin valid_stall = obs_valid; obs_deq = 0; end
      keep_fed();
      step(1'b1, 1'b0);
    end
    vectors += 2;
    if (obs_valid != 20) begin errors++; $display("FAIL stall_valid_held got=%0d exp=20", obs_valid); end
    if (obs_deq != 0) begin errors++; $display("FAIL stall_dequeue_blocked got=%0d exp=0", obs_deq); end
    for (int i = 0; i < 12; i++) begin keep_fed(); step(1'b1, 1'b1); end
  endtask

  task automatic test_disable();
    int valid_after;
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      if (i == 1) obs_valid = 0;
      keep_fed();
      step(1'b0, 1'($urandom_range(1)));
    end
    valid_after = obs_valid;
    vectors += 2;
    if (valid_after != 0) begin errors++; $display("FAIL disable_m_valid got=%0d exp=0", valid_after); end
    if (obs_deq != 0) begin errors++; $display("FAIL disable_dequeue got=%0d exp=0", obs_deq); end
    for (int i = 0; i < 20; i++) begin keep_fed(); step(1'b1, 1'b1); end
  endtask

  task automatic test_random();
    feed_pct = 60;
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(19) != 0), 1'($urandom_range(9) < 7));
    end
    feed_pct = 0;
  endtask

  task automatic test_async_reset();
    keep_fed();
    for (int i = 0; i < 6; i++) begin keep_fed(); step(1'b1, 1'b1); end
    #2;
    reset_n = 1'b0;
    #1;
    vectors += 4;
    if (fifo_dequeue !== 1'b0) begin errors++; $display("FAIL areset_dequeue got=%b exp=0", fifo_dequeue); end
    if (stream.m_valid !== 1'b0) begin errors++; $display("FAIL areset_m_valid got=%b exp=0", stream.m_valid); end
    if (stream.m_data !== '0) begin errors++; $display("FAIL areset_m_data got=%h exp=0", stream.m_data); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL areset_underrun got=%b exp=0", underrun); end
    model_clear();
    enable = 1'b0; fifo_data_valid = 1'b0; fifo_empty = 1'b1; stream.m_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) src_q.push_back(WIDTH'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
  endtask

`ifdef FIFO_READER_UNDERRUN_COUNT_EN
  task automatic test_underrun_count();
    int guard = 0;
    while ((skid_q.size() != 0 || v1 || v2 || src_q.size() != 0) && guard < 40) begin
      step(1'b1, 1'b1);
      guard++;
    end
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) src_q.push_back(WIDTH'($urandom));
    guard = 0;
    while (st != 2 && guard < 30) begin step(1'b1, 1'b0); guard++; end
    vectors++;
    if (st != 2 || guard >= 30) begin errors++; $display("FAIL ucount_prime_timeout got=%0d exp=2", st); end
    repeat (4) step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (underrun_count !== 16'd5) begin errors++; $display("FAIL ucount_five got=%0d exp=5", underrun_count); end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (underrun_count !== 16'd0) begin errors++; $display("FAIL ucount_clear got=%0d exp=0", underrun_count); end
  endtask
`endif

  initial begin
    stream.m_ready = 1'b0;
    test_reset();
    test_priming();
    test_throughput();
    test_backpressure();
    test_disable();
    test_random();
    test_async_reset();
`ifdef FIFO_READER_UNDERRUN_COUNT_EN
    test_underrun_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
